// File: rtl/issue_slot_param_pkg.sv
// issue_pkg: uop bundle, issue-window state enum and opcode constants
// shared by the issue slot, its interface and its wakeup comparators.
package issue_pkg;

  localparam int ISSUE_NUM_WAKEUP = 2;
  localparam int ISSUE_PREG_W     = 7;
  localparam int ISSUE_BRMASK_W   = 12;
  localparam int UOPC_W           = 7;

  localparam logic [UOPC_W-1:0] UOPC_NOP = 7'd0;
  localparam logic [UOPC_W-1:0] UOPC_ADD = 7'd1;
  localparam logic [UOPC_W-1:0] UOPC_LD  = 7'd2;
  localparam logic [UOPC_W-1:0] UOPC_STA = 7'd3;
  localparam logic [UOPC_W-1:0] UOPC_BEQ = 7'd4;

  typedef enum logic [1:0] {
    IW_INVALID = 2'd0,
    IW_ONE     = 2'd1,
    IW_TWO     = 2'd2
  } iw_state_e;

  typedef struct packed {
    logic [UOPC_W-1:0]         uopc;
    logic [31:0]               inst;
    logic [ISSUE_PREG_W-1:0]   pdst;
    logic [ISSUE_PREG_W-1:0]   prs1;
    logic [ISSUE_PREG_W-1:0]   prs2;
    logic                      p1_busy;
    logic                      p2_busy;
    logic [ISSUE_BRMASK_W-1:0] br_mask;
    logic [1:0]                dst_rtype;
    logic [1:0]                lrs1_rtype;
    logic [1:0]                lrs2_rtype;
    logic                      is_br;
    logic                      is_load;
    logic                      is_store;
    logic                      iw_p1_poisoned;
    logic                      iw_p2_poisoned;
  } uop_t;

endpackage

// File: rtl/issue_slot_param_if.sv
// Slot handshake bundle: alloc/clear/grant in, valid/request/uop out.
// master = issue queue control, slave = the slot.
interface issue_slot_param_if;
  import issue_pkg::*;

  logic      alloc_valid;
  uop_t      alloc_uop;
  iw_state_e alloc_iw_state;
  logic      clear;
  logic      grant;
  logic      valid;
  logic      request;
  logic      will_be_valid;
  uop_t      out_uop;
  iw_state_e out_iw_state;

  modport master (
    output alloc_valid, alloc_uop, alloc_iw_state,
    output clear, grant,
    input  valid, request, will_be_valid,
    input  out_uop, out_iw_state
  );

  modport slave (
    input  alloc_valid, alloc_uop, alloc_iw_state,
    input  clear, grant,
    output valid, request, will_be_valid,
    output out_uop, out_iw_state
  );

endinterface

// File: rtl/issue_slot_param_wakeup_match.sv
// wakeup_match: NUM_WAKEUP writeback comparators against one source preg.
// in: wakeup_valid, wakeup_pdst, prs; out: hit.
module wakeup_match
  import issue_pkg::*;
#(
  parameter int NUM_WAKEUP = ISSUE_NUM_WAKEUP,
  parameter int PREG_W     = ISSUE_PREG_W
) (
  input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_W-1:0] wakeup_pdst,
  input  logic [PREG_W-1:0]            prs,
  output logic                         hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_WAKEUP; i++) begin
      if (wakeup_valid[i] &&
          wakeup_pdst[i*PREG_W +: PREG_W] == prs)
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/issue_slot_param.sv
// issue_slot_param: one collapsing issue-queue entry (wakeup, brmask, kill,
// two-part store issue). Ports: clk, rst_n, io (slave), wakeup_*, br_*,
// flush; SPEC_WAKEUP_EN adds spec_wakeup_valid/spec_wakeup_pdst/ld_miss.
module issue_slot_param
  import issue_pkg::*;
#(
  parameter int NUM_WAKEUP = ISSUE_NUM_WAKEUP,
  parameter int PREG_W     = ISSUE_PREG_W,
  parameter int BRMASK_W   = ISSUE_BRMASK_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  issue_slot_param_if.slave            io,
  input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_W-1:0] wakeup_pdst,
  input  logic [BRMASK_W-1:0]          br_resolve_mask,
  input  logic [BRMASK_W-1:0]          br_mispred_mask,
  input  logic                         flush
`ifdef SPEC_WAKEUP_EN
  ,
  input  logic                         spec_wakeup_valid,
  input  logic [PREG_W-1:0]            spec_wakeup_pdst,
  input  logic                         ld_miss
`endif
);

  iw_state_e         state_q, state_d;
  uop_t              uop_q, uop_d, base;
  logic              kill, do_alloc, fire, req;
  logic              hit1, hit2;
  logic              s_hit1, s_hit2;
  logic              rebusy1, rebusy2;
  logic [PREG_W-1:0] prs1_sel, prs2_sel;

  // an empty slot's stale mask must not kill an incoming alloc
  assign kill = flush |
    ((state_q != IW_INVALID) &
     (|(uop_q.br_mask & br_mispred_mask)));

  assign do_alloc = io.alloc_valid &
    ((state_q == IW_INVALID) | io.clear);
  assign fire = io.grant & req;

  // wake the uop being written this cycle, else the stored one
  assign prs1_sel = do_alloc ? io.alloc_uop.prs1 : uop_q.prs1;
  assign prs2_sel = do_alloc ? io.alloc_uop.prs2 : uop_q.prs2;

  wakeup_match #(
    .NUM_WAKEUP (NUM_WAKEUP),
    .PREG_W     (PREG_W)
  ) u_wm1 (
    .wakeup_valid (wakeup_valid),
    .wakeup_pdst  (wakeup_pdst),
    .prs          (prs1_sel),
    .hit          (hit1)
  );

  wakeup_match #(
    .NUM_WAKEUP (NUM_WAKEUP),
    .PREG_W     (PREG_W)
  ) u_wm2 (
    .wakeup_valid (wakeup_valid),
    .wakeup_pdst  (wakeup_pdst),
    .prs          (prs2_sel),
    .hit          (hit2)
  );

`ifdef SPEC_WAKEUP_EN
  assign s_hit1 = spec_wakeup_valid &
    (spec_wakeup_pdst == prs1_sel);
  assign s_hit2 = spec_wakeup_valid &
    (spec_wakeup_pdst == prs2_sel);
  // poison lasts one cycle: a load miss then takes the operand back
  assign rebusy1 = ~do_alloc & uop_q.iw_p1_poisoned & ld_miss;
  assign rebusy2 = ~do_alloc & uop_q.iw_p2_poisoned & ld_miss;
`else
  assign s_hit1  = 1'b0;
  assign s_hit2  = 1'b0;
  assign rebusy1 = 1'b0;
  assign rebusy2 = 1'b0;
`endif

  always_comb begin
    base = do_alloc ? io.alloc_uop : uop_q;
    uop_d = base;
    uop_d.p1_busy = (base.p1_busy & ~hit1 & ~s_hit1) | rebusy1;
    uop_d.p2_busy = (base.p2_busy & ~hit2 & ~s_hit2) | rebusy2;
    uop_d.iw_p1_poisoned = s_hit1;
    uop_d.iw_p2_poisoned = s_hit2;
    uop_d.br_mask = base.br_mask & ~br_resolve_mask;
    // sta half issued: the std remainder only waits on p2
    if (!do_alloc && fire && state_q == IW_TWO)
      uop_d.p1_busy = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uop_q <= '0;
    else        uop_q <= uop_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IW_INVALID;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      kill:     state_d = IW_INVALID;
      do_alloc: state_d = io.alloc_iw_state;
      io.clear: state_d = IW_INVALID;
      fire:     state_d = (state_q == IW_TWO) ? IW_ONE : IW_INVALID;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    req = (state_q != IW_INVALID) & ~kill & ~uop_q.p1_busy &
          (~uop_q.p2_busy | (state_q == IW_TWO));
    io.valid   = state_q != IW_INVALID;
    io.request = req;
    io.will_be_valid = (state_q != IW_INVALID) & ~kill &
      ~(io.grant & (state_q == IW_ONE)) & ~io.clear;
  end

  assign io.out_uop      = uop_q;
  assign io.out_iw_state = state_q;

  a_alloc_legal: assert property (
    @(posedge clk) disable iff (!rst_n)
    io.alloc_valid |-> (state_q == IW_INVALID || io.clear));

  a_grant_legal: assert property (
    @(posedge clk) disable iff (!rst_n)
    io.grant |-> (req || kill));

endmodule
